// File: rtl/fetch_pkg.sv
// Shared fetch-path types and constants.
//   fetch_entry_t : one prefetched instruction {pc, instr}
//   PC_INCR       : byte stride between sequential fetches
package fetch_pkg;

   localparam int unsigned FETCH_XLEN = 32;
   localparam int unsigned PC_INCR    = 4;

   typedef struct packed {
      logic [FETCH_XLEN-1:0] pc;
      logic [FETCH_XLEN-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: circular buffer with push/pop/flush and occupancy count.
//   clk, rst          : clock, async active-high reset
//   push, push_data   : write tail (ignored while flush is high)
//   pop               : advance head (ignored while empty or flushing)
//   flush             : empty the queue at the next edge
//   head_data, empty  : current head entry and empty flag
//   count             : number of valid entries
module fetch_fifo #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 4,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   input  logic             flush,
   output logic [WIDTH-1:0] head_data,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_en, pop_en, full;

   assign empty     = (count_q == '0);
   assign full      = (count_q == CNT_W'(DEPTH));
   assign count     = count_q;
   assign head_data = mem_q[rd_ptr_q];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      push_en  = push && !flush;
      pop_en   = pop && !flush && !empty;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop_en)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         case ({push_en, pop_en})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset; validity is tracked by count_q.
   always_ff @(posedge clk) begin
      if (push_en) mem_q[wr_ptr_q] <= push_data;
   end

   // Request throttling upstream must make a push into a full queue impossible.
   no_overflow_a: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: sequential PC generation, one-cycle memory
// interface, prefetch queue and redirect handling.
//   clk, rst                  : clock, async active-high reset
//   imem_req, imem_addr       : read request and word-aligned byte address
//   imem_rvalid, imem_rdata   : response, exactly one cycle after imem_req
//   redirect_valid/_pc        : branch/jump redirect from execute
//   instr_valid/_ready        : handshake to decode
//   instr, instr_pc           : head instruction and its PC
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned            DATA_WIDTH = 32,
   parameter int unsigned            DEPTH      = 4,
   parameter logic [DATA_WIDTH-1:0]  RESET_PC   = DATA_WIDTH'(32'h0)
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  imem_req,
   output logic [DATA_WIDTH-1:0] imem_addr,
   input  logic                  imem_rvalid,
   input  logic [DATA_WIDTH-1:0] imem_rdata,
   input  logic                  redirect_valid,
   input  logic [DATA_WIDTH-1:0] redirect_pc,
   output logic                  instr_valid,
   input  logic                  instr_ready,
   output logic [DATA_WIDTH-1:0] instr,
   output logic [DATA_WIDTH-1:0] instr_pc
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned OCC_W = CNT_W + 1;
   localparam int unsigned ENT_W = 2 * DATA_WIDTH;

   logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
   logic [DATA_WIDTH-1:0] req_pc_q, req_pc_d;
   logic                  inflight_q, inflight_d;

   logic [CNT_W-1:0]      q_count;
   logic                  q_empty, q_push, q_pop;
   logic [ENT_W-1:0]      q_head, q_push_data;
   logic [OCC_W-1:0]      occupancy;
   logic                  redirect_lsb_unused;

   assign redirect_lsb_unused = ^redirect_pc[1:0];

   // Throttle on registered occupancy only, so decode's ready never reaches imem_req.
   always_comb begin
      occupancy   = OCC_W'(q_count) + OCC_W'(inflight_q);
      imem_req    = !rst && !redirect_valid && (occupancy < OCC_W'(DEPTH));
      imem_addr   = fetch_pc_q;
      instr_valid = !q_empty;
      // Queue entry layout matches fetch_entry_t: {pc, instr}.
      instr_pc    = q_head[ENT_W-1:DATA_WIDTH];
      instr       = q_head[DATA_WIDTH-1:0];
      // A response arriving during a redirect belongs to the old path and is dropped.
      q_push      = imem_rvalid && inflight_q && !redirect_valid;
      q_push_data = {req_pc_q, imem_rdata};
      q_pop       = instr_valid && instr_ready && !redirect_valid;
   end

   // Next fetch PC, in-flight flag and the address a response will belong to.
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      inflight_d = imem_req;
      req_pc_d   = fetch_pc_q;
      if (redirect_valid) begin
         fetch_pc_d = {redirect_pc[DATA_WIDTH-1:2], 2'b00};
      end else if (imem_req) begin
         fetch_pc_d = fetch_pc_q + DATA_WIDTH'(PC_INCR);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc_q <= {RESET_PC[DATA_WIDTH-1:2], 2'b00};
         req_pc_q   <= '0;
         inflight_q <= 1'b0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         req_pc_q   <= req_pc_d;
         inflight_q <= inflight_d;
      end
   end

   fetch_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (q_push),
      .push_data (q_push_data),
      .pop       (q_pop),
      .flush     (redirect_valid),
      .head_data (q_head),
      .empty     (q_empty),
      .count     (q_count)
   );

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: each observed request pushes the expected
// {pc, instr}; each accepted instruction pops and compares.
module tb_fetch_unit;
   import fetch_pkg::*;

   localparam int unsigned DW = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          imem_req;
   logic [DW-1:0] imem_addr;
   logic          imem_rvalid = 1'b0;
   logic [DW-1:0] imem_rdata  = '0;
   logic          redirect_valid = 1'b0;
   logic [DW-1:0] redirect_pc = '0;
   logic          instr_valid;
   logic          instr_ready = 1'b0;
   logic [DW-1:0] instr;
   logic [DW-1:0] instr_pc;

   fetch_entry_t  sb[$];
   logic [DW-1:0] exp_fetch_pc = '0;
   int            n_checks = 0;
   int            n_fail   = 0;
   int            n_req    = 0;
   int            n_pop    = 0;
   int            base;

   fetch_unit #(.DATA_WIDTH(DW), .DEPTH(4), .RESET_PC(32'h0)) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr          (instr),
      .instr_pc       (instr_pc)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] mem_word(input logic [DW-1:0] a);
      return (a == '0) ? 32'h0050_0513 : (a ^ 32'h5A00_0013);
   endfunction

   task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock: sample outputs, update scoreboard, then model the memory response.
   task automatic tick();
      logic          req_s;
      logic [DW-1:0] addr_s;
      logic          fire;
      fetch_entry_t  e;
      #2;
      req_s  = imem_req;
      addr_s = imem_addr;
      fire   = instr_valid && instr_ready && !redirect_valid;
      if (redirect_valid) check_eq("req_during_redirect", DW'(imem_req), 32'd0);
      if (req_s) begin
         check_eq("req_addr", addr_s, exp_fetch_pc);
         e.pc    = exp_fetch_pc;
         e.instr = mem_word(exp_fetch_pc);
         sb.push_back(e);
         exp_fetch_pc = exp_fetch_pc + 32'd4;
         n_req++;
      end
      if (fire) begin
         n_pop++;
         if (sb.size() == 0) begin
            check_eq("pop_with_empty_scoreboard", DW'(sb.size()), 32'd1);
         end else begin
            e = sb.pop_front();
            check_eq("instr_pc", instr_pc, e.pc);
            check_eq("instr", instr, e.instr);
         end
      end
      if (redirect_valid) begin
         sb.delete();
         exp_fetch_pc = {redirect_pc[DW-1:2], 2'b00};
      end
      @(posedge clk);
      #1;
      imem_rvalid = req_s;
      imem_rdata  = mem_word(addr_s);
   endtask

   // Asynchronous reset with optional stale response in the first cycle after release.
   task automatic apply_reset(input bit inject_stale);
      rst = 1'b1;
      #1;
      check_eq("rst_instr_valid", DW'(instr_valid), 32'd0);
      check_eq("rst_imem_req", DW'(imem_req), 32'd0);
      sb.delete();
      exp_fetch_pc = 32'h0;
      repeat (2) begin
         @(posedge clk);
         #1;
         imem_rvalid = 1'b0;
         check_eq("rst_hold_req", DW'(imem_req), 32'd0);
         check_eq("rst_hold_valid", DW'(instr_valid), 32'd0);
      end
      rst         = 1'b0;
      imem_rvalid = inject_stale;
      imem_rdata  = 32'hDEAD_BEEF;
   endtask

   initial begin
      // Reset release and first-fetch latency
      apply_reset(1'b0);
      instr_ready = 1'b1;
      base = n_pop;
      #1;
      check_eq("c1_req", DW'(imem_req), 32'd1);
      check_eq("c1_addr", imem_addr, 32'h0);
      tick();
      #1;
      check_eq("c2_valid", DW'(instr_valid), 32'd0);
      tick();
      #1;
      check_eq("c3_valid", DW'(instr_valid), 32'd1);
      check_eq("c3_instr", instr, 32'h0050_0513);
      check_eq("c3_pc", instr_pc, 32'h0);
      for (int i = 0; i < 10; i++) begin
         check_eq("thru_valid", DW'(instr_valid), 32'd1);
         tick();
      end
      check_eq("thru_pops", DW'(n_pop - base), 32'd10);

      // Decode stalled: queue fills to DEPTH, no loss, then drains in order
      apply_reset(1'b0);
      instr_ready = 1'b0;
      base = n_req;
      repeat (10) tick();
      #1;
      check_eq("stall_reqs", DW'(n_req - base), 32'd4);
      check_eq("stall_req_low", DW'(imem_req), 32'd0);
      check_eq("stall_valid", DW'(instr_valid), 32'd1);
      check_eq("stall_head_pc", instr_pc, 32'h0);
      instr_ready = 1'b1;
      base = n_pop;
      repeat (8) tick();
      check_eq("drain_pops", DW'(n_pop - base), 32'd8);

      // Redirect with three queued and one response in flight
      apply_reset(1'b0);
      instr_ready = 1'b0;
      repeat (4) tick();
      #1;
      check_eq("pre_redirect_valid", DW'(instr_valid), 32'd1);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h100;
      tick();
      redirect_valid = 1'b0;
      instr_ready    = 1'b1;
      #1;
      check_eq("post_redirect_valid", DW'(instr_valid), 32'd0);
      check_eq("post_redirect_req", DW'(imem_req), 32'd1);
      check_eq("post_redirect_addr", imem_addr, 32'h100);
      base = n_pop;
      repeat (8) tick();
      check_eq("redirect_pops", DW'(n_pop - base), 32'd6);

      // Misaligned target is word-aligned
      redirect_valid = 1'b1;
      redirect_pc    = 32'h103;
      tick();
      redirect_valid = 1'b0;
      #1;
      check_eq("align_addr", imem_addr, 32'h100);
      repeat (3) tick();

      // Back-to-back redirects: last wins
      redirect_valid = 1'b1;
      redirect_pc    = 32'h200;
      tick();
      redirect_pc    = 32'h300;
      tick();
      redirect_valid = 1'b0;
      #1;
      check_eq("b2b_addr", imem_addr, 32'h300);
      base = n_pop;
      repeat (8) tick();
      check_eq("b2b_pops", DW'(n_pop - base), 32'd6);

      // Fetch PC wraps at the top of the address space
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFC;
      tick();
      redirect_valid = 1'b0;
      #1;
      check_eq("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
      tick();
      #1;
      check_eq("wrap_req", DW'(imem_req), 32'd1);
      check_eq("wrap_addr1", imem_addr, 32'h0);
      repeat (4) tick();

      // Reset mid-operation with a stale response after release
      instr_ready = 1'b0;
      repeat (3) tick();
      apply_reset(1'b1);
      instr_ready = 1'b1;
      #1;
      check_eq("rerst_req", DW'(imem_req), 32'd1);
      check_eq("rerst_addr", imem_addr, 32'h0);
      check_eq("rerst_valid", DW'(instr_valid), 32'd0);
      base = n_pop;
      repeat (6) tick();
      check_eq("rerst_pops", DW'(n_pop - base), 32'd4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, instruction and PC width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, prefetch queue entries (power of two, 2..16).
REQ-003 SHALL have parameter RESET_PC, default 32'h0, fetch address after reset.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port imem_req  output  1  instruction-memory read request this cycle.
REQ-007 SHALL have port imem_addr  output  DATA_WIDTH  byte address of request, bits [1:0] always 0.
REQ-008 SHALL have port imem_rvalid  input  1  read data valid, exactly one cycle after the matching imem_req.
REQ-009 SHALL have port imem_rdata  input  DATA_WIDTH  instruction word returned.
REQ-010 SHALL have port redirect_valid  input  1  branch/jump redirect from execute.
REQ-011 SHALL have port redirect_pc  input  DATA_WIDTH  redirect target.
REQ-012 SHALL have port instr_valid  output  1  queue head holds a valid instruction.
REQ-013 SHALL have port instr_ready  input  1  decode accepts head this cycle.
REQ-014 SHALL have port instr  output  DATA_WIDTH  head instruction word.
REQ-015 SHALL have port instr_pc  output  DATA_WIDTH  PC of head instruction.

Function
REQ-016 SHALL hold a fetch PC register; each issued request uses imem_addr = fetch PC, then fetch PC += 4, wrapping modulo 2^DATA_WIDTH.
REQ-017 SHALL assert imem_req only when (queue count + in-flight count) < DEPTH and redirect_valid is low.
REQ-018 SHALL write {imem_addr of the request, imem_rdata} into the queue tail on imem_rvalid unless the response is marked dropped.
REQ-019 SHALL present the queue head combinationally from registers: instr_valid = queue not empty; instr/instr_pc = head entry.
REQ-020 SHALL pop the head when instr_valid && instr_ready; simultaneous push and pop SHALL leave count unchanged, with correct ordering.
REQ-021 SHALL never overflow: push while full is impossible by REQ-017; this SHALL be checked by an assertion.
REQ-022 SHALL wrap read/write pointers modulo DEPTH.
REQ-023 SHALL, on redirect_valid: empty the queue at the next edge, load fetch PC with {redirect_pc[DW-1:2],2'b00}, mark any in-flight response dropped, and ignore a same-cycle pop.
REQ-024 SHALL issue the first request to the redirect target in the cycle after redirect_valid.
REQ-025 SHALL handle back-to-back redirects: last one wins, all earlier in-flight responses dropped.
REQ-026 SHALL achieve throughput of one instruction per cycle when instr_ready is held high and no redirects occur (steady state).
REQ-027 SHALL have latency 2 cycles from imem_req to corresponding instr_valid (rvalid at +1, visible at +2).

Reset
REQ-028 SHALL, while rst is high, drive imem_req=0, instr_valid=0, queue empty, in-flight/drop flags cleared, fetch PC=RESET_PC.
REQ-029 SHALL issue imem_req with imem_addr=RESET_PC in the first cycle after rst deasserts.
REQ-030 SHALL, if rst asserts mid-operation, discard queue and in-flight response; an imem_rvalid arriving in the first cycle after reset release SHALL be ignored.

Structure
REQ-031 SHALL place fetch_entry_t (pc, instr) and the PC increment constant 4 in shared package fetch_pkg.
REQ-032 SHALL implement the queue as sub-module fetch_fifo (parametrised DEPTH, push/pop/flush, count output).
REQ-033 SHALL contain no combinational path from imem_rdata to instr or from instr_ready to imem_req.

Verification
REQ-034 Reset release, memory returns 0x00500513 at addr 0, instr_ready=1 -> cycle 1 req addr 0x0, cycle 3 instr_valid=1 instr=0x00500513 instr_pc=0x0, thereafter one instr/cycle at PCs 0x4, 0x8, ...
REQ-035 instr_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 entries held, imem_req low once count+inflight=4, no loss; release -> PCs 0x0..0xC drain in order.
REQ-036 redirect_valid with redirect_pc=0x100 while one request in flight and queue holds 3 -> in-flight response dropped, instr_valid=0 next cycle, next req addr=0x100, first instr_pc=0x100.
REQ-037 redirect_pc=0x103 -> req addr 0x100; redirects on two consecutive cycles (0x200 then 0x300) -> first delivered instr_pc=0x300.
REQ-038 fetch PC at 0xFFFFFFFC -> next request addr 0x00000000.
REQ-039 rst asserted with full queue and request in flight -> instr_valid=0 immediately, after release first req addr=RESET_PC, stale rvalid ignored.
